sar_conv_sched: RTL and testbench

//  Multi-channel conversion scheduler for the SAR ADC. Sequences sample, bit trials and result capture.

---
 rtl/sar_pkg.sv | 19 +
 rtl/sar_conv_sched_if.sv | 32 +++
 rtl/sar_rr_arb.sv | 35 +++
 rtl/sar_conv_sched.sv | 152 +++++++++++++++
 tb/tb_sar_conv_sched.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sar_pkg.sv
// Shared constants for the SAR ADC slice: FSM state encoding, default sizes and a clog2 helper.
// The optional settle phase of the conversion scheduler is enabled with the SAR_SETTLE_EN macro.
package sar_pkg;

    localparam int DEF_NBITS = 4;
    localparam int DEF_NCH   = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SAMPLE = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_TRIAL  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // A one-channel or two-channel mux still needs a 1-bit select.
    function automatic int clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sar_conv_sched_if.sv
// Scheduler bus: analog-side controls (sample, trial, DAC code, mux select, comparator)
// plus the result stream with valid/ready back-pressure.
interface sar_conv_sched_if
    import sar_pkg::*;
#(
    parameter int NBITS = DEF_NBITS,
    parameter int NCH   = DEF_NCH
);
    localparam int CH_W = clog2(NCH);

    logic             SAMPLE;
    logic             SAR_RESET;
    logic [NBITS-1:0] TRIAL;
    logic [NBITS-1:0] DAC_CODE;
    logic [CH_W-1:0]  CH_SEL;
    logic             VCOMP;
    logic [NBITS-1:0] DOUT;
    logic [CH_W-1:0]  DOUT_CH;
    logic             DOUT_VALID;
    logic             DOUT_READY;

    modport master (
        output SAMPLE, SAR_RESET, TRIAL, DAC_CODE, CH_SEL, DOUT, DOUT_CH, DOUT_VALID,
        input  VCOMP, DOUT_READY
    );

    modport slave (
        input  SAMPLE, SAR_RESET, TRIAL, DAC_CODE, CH_SEL, DOUT, DOUT_CH, DOUT_VALID,
        output VCOMP, DOUT_READY
    );

endinterface

// File: rtl/sar_rr_arb.sv
// Combinational round-robin search: first enabled channel strictly after the pointer,
// wrapping NCH-1 -> 0. The pointer itself is last in line.
module sar_rr_arb
    import sar_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    localparam int CH_W = clog2(NCH)
) (
    input  logic [NCH-1:0]  mask,
    input  logic [CH_W-1:0] ptr,
    output logic [CH_W-1:0] grant,
    output logic            any
);
    logic [CH_W-1:0] cand_idx [NCH];
    logic [NCH-1:0]  hit;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_cand
            assign cand_idx[gi] = CH_W'((int'(ptr) + gi + 1) % NCH);
            assign hit[gi]      = mask[cand_idx[gi]];
        end
    endgenerate

    // Scan from the farthest candidate so the nearest hit is written last.
    always_comb begin
        grant = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (hit[i]) grant = cand_idx[i];
        end
    end

    assign any = |mask;

endmodule

// File: rtl/sar_conv_sched.sv
// Multi-channel SAR conversion scheduler: sample, MSB-first bit trials, result capture and a
// valid/ready output register. Define SAR_SETTLE_EN to add a programmable settle phase.
module sar_conv_sched
    import sar_pkg::*;
#(
    parameter int NBITS = DEF_NBITS,
    parameter int NCH   = DEF_NCH
`ifdef SAR_SETTLE_EN
    ,
    parameter int SETTLE_W = 3
`endif
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                EN,
    input  logic [NCH-1:0]      CH_MASK,
`ifdef SAR_SETTLE_EN
    input  logic [SETTLE_W-1:0] SETTLE_CYC,
`endif
    sar_conv_sched_if.master    bus
);
    localparam int CH_W = clog2(NCH);
    localparam logic [NBITS-1:0] MSB_HOT = {1'b1, {(NBITS-1){1'b0}}};

    logic [2:0]       state_reg;
    logic [CH_W-1:0]  ptr_reg;
    logic [CH_W-1:0]  ch_reg;
    logic [CH_W-1:0]  dout_ch_reg;
    logic [NBITS-1:0] code_reg;
    logic [NBITS-1:0] trial_reg;
    logic [NBITS-1:0] res_reg;
    logic [NBITS-1:0] dout_reg;
    logic             valid_reg;
    logic             sample_reg;
    logic             sar_reset_reg;
`ifdef SAR_SETTLE_EN
    logic [SETTLE_W-1:0] settle_cnt_reg;
`endif

    logic [CH_W-1:0]  grant;
    logic             any_en;
    logic             can_load;
    logic             launch;
    logic [NBITS-1:0] keep_code;

    sar_rr_arb #(.NCH(NCH)) u_arb (
        .mask  (CH_MASK),
        .ptr   (ptr_reg),
        .grant (grant),
        .any   (any_en)
    );

    // Active trial bit replaced by the comparator decision.
    assign keep_code = (code_reg & ~trial_reg) | (bus.VCOMP ? trial_reg : '0);
    assign can_load  = !valid_reg || bus.DOUT_READY;
    assign launch    = EN && any_en &&
                       ((state_reg == ST_IDLE) || ((state_reg == ST_DONE) && can_load));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg     <= ST_IDLE;
            ptr_reg       <= CH_W'(NCH - 1);
            ch_reg        <= '0;
            dout_ch_reg   <= '0;
            code_reg      <= '0;
            trial_reg     <= '0;
            res_reg       <= '0;
            dout_reg      <= '0;
            valid_reg     <= 1'b0;
            sample_reg    <= 1'b0;
            sar_reset_reg <= 1'b1;
`ifdef SAR_SETTLE_EN
            settle_cnt_reg <= '0;
`endif
        end else begin
            if (valid_reg && bus.DOUT_READY) valid_reg <= 1'b0;

            case (state_reg)
                ST_SAMPLE: begin
                    sample_reg    <= 1'b0;
                    sar_reset_reg <= 1'b0;
`ifdef SAR_SETTLE_EN
                    if (SETTLE_CYC != '0) begin
                        state_reg      <= ST_SETTLE;
                        settle_cnt_reg <= SETTLE_CYC - SETTLE_W'(1);
                    end else begin
                        state_reg <= ST_TRIAL;
                        trial_reg <= MSB_HOT;
                        code_reg  <= MSB_HOT;
                    end
`else
                    state_reg <= ST_TRIAL;
                    trial_reg <= MSB_HOT;
                    code_reg  <= MSB_HOT;
`endif
                end
`ifdef SAR_SETTLE_EN
                ST_SETTLE: begin
                    if (settle_cnt_reg == '0) begin
                        state_reg <= ST_TRIAL;
                        trial_reg <= MSB_HOT;
                        code_reg  <= MSB_HOT;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg - SETTLE_W'(1);
                    end
                end
`endif
                ST_TRIAL: begin
                    trial_reg <= trial_reg >> 1;
                    if (trial_reg[0]) begin
                        res_reg   <= keep_code;
                        code_reg  <= '0;
                        state_reg <= ST_DONE;
                    end else begin
                        code_reg <= keep_code | (trial_reg >> 1);
                    end
                end
                ST_DONE: begin
                    // Result waits here until the output register is free.
                    if (can_load) begin
                        dout_reg      <= res_reg;
                        dout_ch_reg   <= ch_reg;
                        valid_reg     <= 1'b1;
                        state_reg     <= ST_IDLE;
                        sar_reset_reg <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase

            if (launch) begin
                state_reg     <= ST_SAMPLE;
                sample_reg    <= 1'b1;
                sar_reset_reg <= 1'b1;
                ch_reg        <= grant;
                ptr_reg       <= grant;
                code_reg      <= '0;
                trial_reg     <= '0;
            end
        end
    end

    assign bus.SAMPLE     = sample_reg;
    assign bus.SAR_RESET  = sar_reset_reg;
    assign bus.TRIAL      = trial_reg;
    assign bus.DAC_CODE   = code_reg;
    assign bus.CH_SEL     = ch_reg;
    assign bus.DOUT       = dout_reg;
    assign bus.DOUT_CH    = dout_ch_reg;
    assign bus.DOUT_VALID = valid_reg;

endmodule

// File: tb/tb_sar_conv_sched.sv
// Scoreboard bench for sar_conv_sched: expected results queued by stimulus, popped by a monitor.
// Settle-phase checks are compiled in when SAR_SETTLE_EN is defined.
module tb_sar_conv_sched;
    import sar_pkg::*;

    typedef struct packed {
        logic [3:0] d;
        logic [1:0] ch;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] ch_mask = 4'b0000;
    logic       ready = 1'b1;
    logic [3:0] vin [4];
`ifdef SAR_SETTLE_EN
    logic [2:0] settle_cyc = 3'd0;
`endif

    res_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;
    logic [1:0] ch_at_sample = 2'd0;

    sar_conv_sched_if #(.NBITS(4), .NCH(4)) bus ();

    // Comparator model: keep the trial bit when the channel voltage reaches the DAC code.
    assign bus.VCOMP      = (vin[bus.CH_SEL] >= bus.DAC_CODE);
    assign bus.DOUT_READY = ready;

    sar_conv_sched #(.NBITS(4), .NCH(4)) dut (
        .CLK        (clk),
        .RESET_N    (rst_n),
        .EN         (en),
        .CH_MASK    (ch_mask),
`ifdef SAR_SETTLE_EN
        .SETTLE_CYC (settle_cyc),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
            $display("check %-16s act=%0h exp=%0h ok", name, act, exp);
        end else begin
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endfunction

    // Monitor: pops the scoreboard on every transfer and checks CH_SEL holds through the trials.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.DOUT_VALID && ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_res", 1, 0);
                end else begin
                    res_t e;
                    e = sb.pop_front();
                    check("dout", int'(bus.DOUT), int'(e.d));
                    check("dout_ch", int'(bus.DOUT_CH), int'(e.ch));
                end
            end
            if (bus.SAMPLE) ch_at_sample = bus.CH_SEL;
            if (bus.TRIAL[0]) check("ch_sel_stable", int'(bus.CH_SEL), int'(ch_at_sample));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1 ready = r;
    endtask

    // One isolated conversion; returns SAMPLE latency from EN and VALID latency from SAMPLE.
    task automatic run_one(input logic [3:0] d, input logic [1:0] ch,
                           output int samp_lat, output int valid_lat);
        res_t e;
        e.d  = d;
        e.ch = ch;
        sb.push_back(e);
        @(negedge clk);
        en = 1'b1;
        samp_lat = 0;
        do begin
            @(negedge clk);
            samp_lat++;
        end while (!bus.SAMPLE && samp_lat < 20);
        if (!bus.SAMPLE) check("sample_timeout", 0, 1);
        en = 1'b0;
        valid_lat = 0;
        do begin
            @(negedge clk);
            valid_lat++;
        end while (!bus.DOUT_VALID && valid_lat < 40);
        if (!bus.DOUT_VALID) check("valid_timeout", 0, 1);
        repeat (3) @(negedge clk);
        check("drained", sb.size(), 0);
    endtask

    task automatic wait_drain(input int budget);
        int cyc = 0;
        while (sb.size() != 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check("drain_bound", sb.size(), 0);
    endtask

    initial begin
        int sl, vl, cnt, cyc;
        logic held_ok;
        res_t e;
        foreach (vin[i]) vin[i] = 4'h0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_sar_reset", int'(bus.SAR_RESET), 1);
        check("rst_sample", int'(bus.SAMPLE), 0);
        check("rst_trial", int'(bus.TRIAL), 0);
        check("rst_dac_code", int'(bus.DAC_CODE), 0);
        check("rst_valid", int'(bus.DOUT_VALID), 0);
        check("rst_ch_sel", int'(bus.CH_SEL), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single channel, vin=0xA, latency
        ch_mask = 4'b0001;
        vin[0]  = 4'hA;
        run_one(4'hA, 2'd0, sl, vl);
        check("t1_sample_lat", sl, 1);
        check("t1_valid_lat", vl, 6);

        // 2: round robin over 1011 from reset -> 0,1,3,0,1
        do_reset();
        ch_mask = 4'b1011;
        vin[0] = 4'h3; vin[1] = 4'h5; vin[2] = 4'hE; vin[3] = 4'hC;
        e.d = 4'h3; e.ch = 2'd0; sb.push_back(e);
        e.d = 4'h5; e.ch = 2'd1; sb.push_back(e);
        e.d = 4'hC; e.ch = 2'd3; sb.push_back(e);
        e.d = 4'h3; e.ch = 2'd0; sb.push_back(e);
        e.d = 4'h5; e.ch = 2'd1; sb.push_back(e);
        en  = 1'b1;
        cnt = 0;
        cyc = 0;
        while (cnt < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.SAMPLE) cnt++;
        end
        en = 1'b0;
        check("t2_launches", cnt, 5);
        wait_drain(60);
        repeat (8) @(negedge clk);
        check("t2_no_extra", int'(bus.DOUT_VALID), 0);

        // 3: all-ones and all-zeros codes, LSB included
        do_reset();
        ch_mask = 4'b0001;
        vin[0]  = 4'hF;
        run_one(4'hF, 2'd0, sl, vl);
        vin[0]  = 4'h0;
        run_one(4'h0, 2'd0, sl, vl);

        // 4: back-pressure, second result parked in DONE
        do_reset();
        set_ready(1'b0);
        ch_mask = 4'b0001;
        vin[0]  = 4'h6;
        e.d = 4'h6; e.ch = 2'd0; sb.push_back(e);
        e.d = 4'h9; e.ch = 2'd0; sb.push_back(e);
        @(negedge clk);
        en  = 1'b1;
        cnt = 0;
        cyc = 0;
        while (cnt < 2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.SAMPLE) cnt++;
        end
        vin[0] = 4'h9;
        en     = 1'b0;
        check("t4_launches", cnt, 2);
        check("t4_first_valid", int'(bus.DOUT_VALID), 1);
        held_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.DOUT !== 4'h6 || bus.DOUT_CH !== 2'd0 || bus.DOUT_VALID !== 1'b1) held_ok = 1'b0;
        end
        check("t4_hold_stable", int'(held_ok), 1);
        check("t4_parked_trial", int'(bus.TRIAL), 0);
        check("t4_parked_sample", int'(bus.SAMPLE), 0);
        set_ready(1'b1);
        wait_drain(20);
        repeat (3) @(negedge clk);
        check("t4_no_dup", int'(bus.DOUT_VALID), 0);

        // 5: asynchronous reset mid-trial on ch1 with a held result pending
        do_reset();
        set_ready(1'b0);
        ch_mask = 4'b0011;
        vin[0] = 4'h2; vin[1] = 4'h7;
        @(negedge clk);
        en  = 1'b1;
        cyc = 0;
        while (!(bus.TRIAL == 4'b0100 && bus.CH_SEL == 2'd1) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("t5_reach_k2", int'(bus.TRIAL), 4'b0100);
        check("t5_held_valid", int'(bus.DOUT_VALID), 1);
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        check("t5_sar_reset", int'(bus.SAR_RESET), 1);
        check("t5_sample", int'(bus.SAMPLE), 0);
        check("t5_trial", int'(bus.TRIAL), 0);
        check("t5_dac_code", int'(bus.DAC_CODE), 0);
        check("t5_ch_sel", int'(bus.CH_SEL), 0);
        check("t5_valid", int'(bus.DOUT_VALID), 0);
        check("t5_dout", int'(bus.DOUT), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_ready(1'b1);
        run_one(4'h2, 2'd0, sl, vl);

`ifdef SAR_SETTLE_EN
        // 6: settle phase stretches latency by SETTLE_CYC
        do_reset();
        ch_mask    = 4'b0001;
        vin[0]     = 4'h5;
        settle_cyc = 3'd3;
        run_one(4'h5, 2'd0, sl, vl);
        check("t6_lat_settle3", vl, 9);
        settle_cyc = 3'd0;
        run_one(4'h5, 2'd0, sl, vl);
        check("t6_lat_settle0", vl, 6);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
